// File: rtl/truth_table_pkg.sv
// truth_table_pkg: shared op codes and sweep states for truth-table checkers
package truth_table_pkg;
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_BUF  = 3'd6;
  localparam logic [2:0] OP_NOT  = 3'd7;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/truth_table_sweeper_gate_model.sv
// gate_model: golden N-input gate built from reduction operators
module gate_model
  import truth_table_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [N_IN-1:0] vec,
  input  logic [2:0]      op,
  output logic            exp
);
  logic a, o, x;
  assign a = &vec;
  assign o = |vec;
  assign x = ^vec;
  assign exp = op == OP_AND  ? a :
               op == OP_OR   ? o :
               op == OP_XOR  ? x :
               op == OP_NAND ? ~a :
               op == OP_NOR  ? ~o :
               op == OP_XNOR ? ~x :
               op == OP_BUF  ? vec[0] : ~vec[0];
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: exhaustive vector sweep with hold, golden compare and result capture
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int HOLD = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic            dut_out,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err_vec
);
  localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
  localparam int EW = N_IN + 1;
  localparam logic [HW-1:0] HLAST = HW'(HOLD - 1);
  state_e state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d, ferr_q, ferr_d;
  logic [EW-1:0] err_q, err_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [2:0] op_q, op_d;
  logic busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic exp, sample, miss, last;
  gate_model #(.N_IN(N_IN)) u_gate (
    .vec(vec_q),
    .op (op_q),
    .exp(exp)
  );
  assign sample = hold_q == HLAST;
  assign miss = sample && (dut_out != exp);
  assign last = &vec_q;
  // next state: (re)start from IDLE/DONE, step hold/vector and score while applying
  always_comb begin
    state_d = state_q;
    vec_d = vec_q;
    ferr_d = ferr_q;
    err_d = err_q;
    hold_d = hold_q;
    op_d = op_q;
    busy_d = busy_q;
    done_d = done_q;
    pass_d = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_APPLY;
          op_d = op;
          vec_d = '0;
          hold_d = '0;
          err_d = '0;
          ferr_d = '0;
          busy_d = 1'b1;
          done_d = 1'b0;
          pass_d = 1'b0;
        end
      end
      ST_APPLY: begin
        hold_d = sample ? '0 : hold_q + HW'(1);
        err_d = miss ? err_q + EW'(1) : err_q;
        ferr_d = (miss && err_q == '0) ? vec_q : ferr_q;
        vec_d = (sample && !last) ? vec_q + N_IN'(1) : vec_q;
        if (sample && last) begin
          state_d = ST_DONE;
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = err_d == '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // state and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q <= '0;
      ferr_q <= '0;
      err_q <= '0;
      hold_q <= '0;
      op_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q <= vec_d;
      ferr_q <= ferr_d;
      err_q <= err_d;
      hold_q <= hold_d;
      op_q <= op_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end
  assign vec = vec_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
  assign err_count = err_q;
  assign first_err_vec = ferr_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed and random sweeps against a popcount-based reference
module tb_truth_table_sweeper;
  logic clk = 1'b0;
  logic rst, start, sel, stuck;
  logic [2:0] op;
  int dop;
  logic [7:0] flip;
  logic [1:0] vec_a, ferr_a;
  logic [2:0] vec_b, ferr_b, err_a;
  logic [3:0] err_b;
  logic busy_a, done_a, pass_a, busy_b, done_b, pass_b, dut_a, dut_b;
  logic [31:0] obs_vec, obs_err, obs_ferr;
  logic obs_busy, obs_done, obs_pass;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  function automatic bit gate_ref(int v, int o, int n);
    int ones = $countones(v);
    case (o)
      0: return ones == n;
      1: return ones > 0;
      2: return ones % 2 == 1;
      3: return ones != n;
      4: return ones == 0;
      5: return ones % 2 == 0;
      6: return v % 2 == 1;
      default: return v % 2 == 0;
    endcase
  endfunction
  assign dut_a = stuck ? 1'b0 : gate_ref(int'(vec_a), dop, 2) ^ flip[vec_a];
  assign dut_b = stuck ? 1'b0 : gate_ref(int'(vec_b), dop, 3) ^ flip[vec_b];
  truth_table_sweeper #(.N_IN(2), .HOLD(4)) u_a (
    .clk(clk), .rst(rst), .start(start & ~sel), .op(op), .dut_out(dut_a),
    .vec(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_err_vec(ferr_a)
  );
  truth_table_sweeper #(.N_IN(3), .HOLD(1)) u_b (
    .clk(clk), .rst(rst), .start(start & sel), .op(op), .dut_out(dut_b),
    .vec(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_err_vec(ferr_b)
  );
  assign obs_vec = sel ? 32'(vec_b) : 32'(vec_a);
  assign obs_err = sel ? 32'(err_b) : 32'(err_a);
  assign obs_ferr = sel ? 32'(ferr_b) : 32'(ferr_a);
  assign obs_busy = sel ? busy_b : busy_a;
  assign obs_done = sel ? done_b : done_a;
  assign obs_pass = sel ? pass_b : pass_a;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_vec"}, obs_vec, 0);
    check({tag, "_busy"}, 32'(obs_busy), 0);
    check({tag, "_done"}, 32'(obs_done), 0);
    check({tag, "_pass"}, 32'(obs_pass), 0);
    check({tag, "_err"}, obs_err, 0);
    check({tag, "_ferr"}, obs_ferr, 0);
  endtask
  task automatic calc(input int n, input int o, output int e, output int f);
    e = 0;
    f = 0;
    for (int v = 0; v < (1 << n); v++) begin
      bit d = stuck ? 1'b0 : gate_ref(v, dop, n) ^ flip[v];
      if (d != gate_ref(v, o, n)) begin
        if (e == 0) f = v;
        e++;
      end
    end
  endtask
  task automatic check_result(input int n, input int e, input int f);
    check("done", 32'(obs_done), 1);
    check("busy_end", 32'(obs_busy), 0);
    check("pass", 32'(obs_pass), 32'(e == 0));
    check("err_count", obs_err, e);
    check("first_err_vec", obs_ferr, f);
    check("vec_end", obs_vec, (1 << n) - 1);
  endtask
  task automatic sweep(input int o);
    int n = sel ? 3 : 2;
    int h = sel ? 1 : 4;
    int tot = (1 << n) * h;
    int e, f;
    calc(n, o, e, f);
    @(negedge clk);
    start = 1'b1;
    op = 3'(o);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < tot; c++) begin
      if (c > 0) @(negedge clk);
      check("vec_step", obs_vec, c / h);
      check("busy_run", 32'(obs_busy), 1);
      check("done_early", 32'(obs_done), 0);
    end
    @(negedge clk);
    check_result(n, e, f);
    @(negedge clk);
    check("done_held", 32'(obs_done), 1);
    check("err_held", obs_err, e);
  endtask
  task automatic wait_done(input int max);
    for (int i = 0; i < max && !obs_done; i++) @(negedge clk);
    check("done_timeout", 32'(obs_done), 1);
  endtask
  initial begin
    int e, f, o;
    sel = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    op = '0;
    stuck = 1'b0;
    dop = 0;
    flip = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    sweep(0);
    stuck = 1'b1;
    sweep(1);
    stuck = 1'b0;
    dop = 5;
    sweep(2);
    repeat (6) begin
      o = int'($urandom_range(0, 7));
      dop = $urandom_range(0, 1) == 1 ? o : int'($urandom_range(0, 7));
      flip = $urandom_range(0, 2) == 0 ? 8'($urandom) : 8'd0;
      stuck = $urandom_range(0, 5) == 0;
      sweep(o);
    end
    stuck = 1'b0;
    flip = '0;
    dop = 1;
    @(negedge clk);
    start = 1'b1;
    op = 3'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("mid_reset");
    rst = 1'b1;
    start = 1'b1;
    op = 3'd7;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check_zero("rst_start");
    sweep(1);
    dop = 2;
    calc(2, 1, e, f);
    @(negedge clk);
    start = 1'b1;
    op = 3'd1;
    @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 5) op = 3'd2;
      check("held_vec", obs_vec, c / 4);
      check("held_busy", 32'(obs_busy), 1);
    end
    @(negedge clk);
    check_result(2, e, f);
    @(negedge clk);
    check("restart_busy", 32'(obs_busy), 1);
    check("restart_done", 32'(obs_done), 0);
    check("restart_pass", 32'(obs_pass), 0);
    check("restart_err", obs_err, 0);
    check("restart_ferr", obs_ferr, 0);
    check("restart_vec", obs_vec, 0);
    start = 1'b0;
    wait_done(20);
    calc(2, 2, e, f);
    check("restart_err_final", obs_err, e);
    check("restart_pass_final", 32'(obs_pass), 32'(e == 0));
    sel = 1'b1;
    dop = 3;
    sweep(3);
    repeat (4) begin
      o = int'($urandom_range(0, 7));
      dop = $urandom_range(0, 1) == 1 ? o : int'($urandom_range(0, 7));
      flip = $urandom_range(0, 1) == 0 ? 8'($urandom) : 8'd0;
      sweep(o);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
